led7seg_scan_scheduler: RTL and testbench
=========================================

Name: led7seg_scan_scheduler

Overview:
Sequences the 8-digit 74HC595 seven-segment shift controller. It holds a double-buffered 8-entry segment frame and scans the digits round-robin at a paced rate. For each digit it issues one {segments, one-hot digit select} word over the controller's vld/rdy handshake. Frame producers (timer, mode counter) write the shadow buffer and commit; the new frame takes effect only at a frame boundary, so the display never shows a mix of two frames.

Parameters:
SCAN_DIV, 12500, clk cycles from end of one transfer to the next vld assertion (>=1; 100 us at 125 MHz)
BLINK_DIV, 62500000, clk cycles per blink phase toggle (>=1; 0.5 s at 125 MHz)
BLANK_SEG, 8'hFF, segment byte that turns a digit fully off

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low (0 = reset)
wr_en  in  1  write one shadow entry this cycle
wr_addr  in  3  shadow entry index 0..7
wr_seg  in  8  segment byte for wr_addr
commit  in  1  single-cycle request to publish shadow at next frame boundary
blank  in  1  force all digits to BLANK_SEG
blink_mask  in  8  bit i=1: digit i blinks
dat  out  16  {segment byte, digit select}; digit select = 8'h01 << digit index
vld  out  1  dat valid to shift controller
rdy  in  1  shift controller ready; transfer occurs when vld && rdy
frame_done  out  1  one-cycle pulse after the digit-7 transfer
cur_digit  out  3  index of digit being issued or last issued
commit_pending  out  1  commit accepted, swap not yet done

Behaviour:
- Reset (rst=0, async) sets all of the following: dat={BLANK_SEG,8'h01}, vld=0, frame_done=0, cur_digit=0, commit_pending=0. Active and shadow buffers are all BLANK_SEG. Gap counter=0, blink counter=0, blink phase=ON.
- FSM has 2 states.
  - WAIT: the gap counter increments each cycle. When it reaches SCAN_DIV-1, the FSM latches dat for cur_digit, sets vld=1, clears the counter and goes to ISSUE.
  - ISSUE: vld=1 and dat are held stable until rdy=1. On the vld&&rdy cycle, vld drops on the next edge, cur_digit increments (7 wraps to 0) and the FSM returns to WAIT.
  - vld is never deasserted without a transfer.
- First vld after reset release occurs SCAN_DIV cycles later. Minimum digit period is SCAN_DIV+1 cycles when rdy is held at 1.
- Segment byte selection, evaluated at the latch cycle:
  - blank=1 → BLANK_SEG.
  - Otherwise, if blink phase=OFF and blink_mask[idx]=1 → BLANK_SEG.
  - Otherwise → active[idx].
  - Changes to blank or blink_mask during ISSUE do not alter the held dat.
- Blink counter is free-running. At BLINK_DIV-1 it wraps to 0 and the phase toggles. It is independent of the FSM.
- Shadow write: on wr_en, shadow[wr_addr] <= wr_seg on the next edge. Writes are allowed at any time and never stall the scan.
- Commit: commit=1 sets commit_pending. A second commit while pending has no further effect.
- Frame boundary is the vld&&rdy cycle for digit 7. On that cycle:
  - frame_done pulses the next cycle.
  - If commit_pending=1, or commit=1 in that same cycle, active <= shadow (all 8 entries) and commit_pending clears.
- Write in the same cycle as the swap: active receives the pre-write shadow value for that entry. The shadow still receives the write, and it appears at the next commit.
- Digit 0 of the new frame is the first digit using the swapped data.
- Reset mid-ISSUE aborts immediately: vld=0, no frame_done, pending commit lost.

Test Plan:
- Reset release, SCAN_DIV=4, rdy=1 → vld first high 4 cycles after release with dat=16'hFF01. Digit selects then step 01,02,…,80,01 with one transfer every 5 cycles. frame_done pulses once per 8 transfers.
- Backpressure: hold rdy=0 for 20 cycles during digit 3 → vld stays 1 and dat stays {active[3],8'h08} unchanged. Transfer completes the cycle rdy rises, and cur_digit becomes 4.
- Write shadow[0..7]=8'hC0 then commit mid-frame at digit 2 → digits 3–7 still output FF, and commit_pending=1. After digit-7 transfer, frame_done fires and pending clears. Next frame outputs C0 for all digits.
- Commit asserted exactly on the digit-7 transfer cycle, with a simultaneous wr_en addr 0 data 8'h92 → swap occurs. Digit 0 shows the old shadow[0] value, not 92. After a later commit, digit 0 shows 92.
- BLINK_DIV=32, blink_mask=8'h10, shadow committed to 8'hA4 → digit 4 alternates A4/FF per phase, and other digits are constantly A4. With blank=1, all digits output FF.
- Assert rst=0 while vld=1 at digit 5 → vld=0 and dat=16'hFF01 asynchronously, commit_pending=0. After release, the scan restarts at digit 0 with a blank frame.

Source files
------------

// File: rtl/led7seg_scan_scheduler.sv
// ---------------------------------------------------------------------------
// led7seg_scan_scheduler
//
// Purpose:
//   Drives an 8-digit 74HC595 seven-segment shift controller. Holds a
//   double-buffered 8-entry segment frame (shadow written by producers,
//   active used for display) and scans digits round-robin at a paced rate,
//   issuing one {segments, one-hot digit select} word per digit over a
//   vld/rdy handshake. A committed shadow frame is copied into the active
//   buffer only on the digit-7 transfer, so a displayed frame is never a
//   mix of two frames.
//
// Ports:
//   clk            system clock
//   rst            asynchronous reset, active-low
//   wr_en          write shadow[wr_addr] <= wr_seg
//   wr_addr        shadow entry index 0..7
//   wr_seg         segment byte to write
//   commit         one-cycle request to publish shadow at next frame boundary
//   blank          force every digit to BLANK_SEG
//   blink_mask     bit i set: digit i blanks during the blink OFF phase
//   dat            {segment byte, 8'h01 << digit}
//   vld            dat valid towards the shift controller
//   rdy            shift controller ready; transfer on vld && rdy
//   frame_done     one-cycle pulse after the digit-7 transfer
//   cur_digit      digit being issued or last issued
//   commit_pending commit accepted, swap not yet performed
// ---------------------------------------------------------------------------
module led7seg_scan_scheduler #(
  parameter int          SCAN_DIV  = 12500,
  parameter int          BLINK_DIV = 62500000,
  parameter logic [7:0]  BLANK_SEG = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [7:0]  wr_seg,
  input  logic        commit,
  input  logic        blank,
  input  logic [7:0]  blink_mask,
  output logic [15:0] dat,
  output logic        vld,
  input  logic        rdy,
  output logic        frame_done,
  output logic [2:0]  cur_digit,
  output logic        commit_pending
);

  localparam int GAP_W   = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  localparam logic [0:0] S_WAIT  = 1'b0;
  localparam logic [0:0] S_ISSUE = 1'b1;

  logic [0:0]         r_state;
  logic [GAP_W-1:0]   r_gap;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_blink_off;
  logic [15:0]        r_dat;
  logic               r_vld;
  logic               r_frame_done;
  logic [2:0]         r_cur_digit;
  logic               r_commit_pending;
  logic [7:0]         r_active [8];
  logic [7:0]         r_shadow [8];

  logic               w_xfer;
  logic               w_boundary;
  logic               w_swap;
  logic [7:0]         w_seg_sel;

  assign w_xfer     = r_vld & rdy;
  assign w_boundary = w_xfer & (r_cur_digit == 3'd7);
  // A commit arriving on the boundary cycle itself is honoured immediately.
  assign w_swap     = w_boundary & (r_commit_pending | commit);

  // Segment byte chosen for the digit about to be latched.
  always_comb begin
    w_seg_sel = r_active[r_cur_digit];
    if (blank) begin
      w_seg_sel = BLANK_SEG;
    end else if (r_blink_off && blink_mask[r_cur_digit]) begin
      w_seg_sel = BLANK_SEG;
    end
  end

  // Frame buffers. The swap reads the pre-edge shadow, so a write landing in
  // the swap cycle reaches the shadow only and waits for the next commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        r_active[i] <= BLANK_SEG;
        r_shadow[i] <= BLANK_SEG;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (w_swap) begin
          r_active[i] <= r_shadow[i];
        end
        if (wr_en && (wr_addr == 3'(i))) begin
          r_shadow[i] <= wr_seg;
        end
      end
    end
  end

  // Free-running blink phase, independent of the scan.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_blink_cnt <= '0;
      r_blink_off <= 1'b0;
    end else if (r_blink_cnt == BLINK_LAST) begin
      r_blink_cnt <= '0;
      r_blink_off <= ~r_blink_off;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  // Commit bookkeeping and frame-done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_commit_pending <= 1'b0;
      r_frame_done     <= 1'b0;
    end else begin
      r_frame_done <= w_boundary;
      if (w_swap) begin
        r_commit_pending <= 1'b0;
      end else if (commit) begin
        r_commit_pending <= 1'b1;
      end
    end
  end

  // Scan FSM: pace in WAIT, then hold the latched word in ISSUE until taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_WAIT;
      r_gap       <= '0;
      r_dat       <= {BLANK_SEG, 8'h01};
      r_vld       <= 1'b0;
      r_cur_digit <= 3'd0;
    end else begin
      case (r_state)
        S_WAIT: begin
          if (r_gap == GAP_LAST) begin
            r_gap   <= '0;
            r_dat   <= {w_seg_sel, 8'h01 << r_cur_digit};
            r_vld   <= 1'b1;
            r_state <= S_ISSUE;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        S_ISSUE: begin
          if (rdy) begin
            r_vld       <= 1'b0;
            r_cur_digit <= r_cur_digit + 3'd1;
            r_state     <= S_WAIT;
          end
        end
        default: begin
          r_state <= S_WAIT;
          r_vld   <= 1'b0;
        end
      endcase
    end
  end

  assign dat            = r_dat;
  assign vld            = r_vld;
  assign frame_done     = r_frame_done;
  assign cur_digit      = r_cur_digit;
  assign commit_pending = r_commit_pending;

endmodule

// File: tb/tb_led7seg_scan_scheduler.sv
// ---------------------------------------------------------------------------
// tb_led7seg_scan_scheduler
//
// Self-checking bench. A transaction-level reference model predicts, from the
// scan timing rules (next vld rise = previous transfer edge + SCAN_DIV), the
// blink phase (edges since reset / BLINK_DIV), and the double-buffer rules,
// every output on every cycle. Stimulus mixes directed scenarios with
// randomized rdy backpressure, shadow writes, commits, blank and blink masks.
// ---------------------------------------------------------------------------
module tb_led7seg_scan_scheduler;

  localparam int SD = 4;
  localparam int BD = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [7:0]  wr_seg;
  logic        commit;
  logic        blank;
  logic [7:0]  blink_mask;
  logic [15:0] dat;
  logic        vld;
  logic        rdy;
  logic        frame_done;
  logic [2:0]  cur_digit;
  logic        commit_pending;

  led7seg_scan_scheduler #(
    .SCAN_DIV  (SD),
    .BLINK_DIV (BD),
    .BLANK_SEG (8'hFF)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_seg         (wr_seg),
    .commit         (commit),
    .blank          (blank),
    .blink_mask     (blink_mask),
    .dat            (dat),
    .vld            (vld),
    .rdy            (rdy),
    .frame_done     (frame_done),
    .cur_digit      (cur_digit),
    .commit_pending (commit_pending)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0]  m_shadow [8];
  logic [7:0]  m_active [8];
  logic        m_pending;
  logic        m_vld;
  logic        m_fd;
  logic [15:0] m_dat;
  int          m_digit;
  int          m_cyc;
  int          m_next_rise;
  int          n_frames;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_shadow[i] = 8'hFF;
      m_active[i] = 8'hFF;
    end
    m_pending   = 1'b0;
    m_vld       = 1'b0;
    m_fd        = 1'b0;
    m_dat       = 16'hFF01;
    m_digit     = 0;
    m_cyc       = 0;
    m_next_rise = SD;
  endtask

  task automatic check_outputs();
    check_eq("vld",            vld,            m_vld);
    check_eq("dat",            dat,            m_dat);
    check_eq("frame_done",     frame_done,     m_fd);
    check_eq("cur_digit",      cur_digit,      m_digit[2:0]);
    check_eq("commit_pending", commit_pending, m_pending);
  endtask

  // One clock: predict the effect of the coming edge from the current inputs,
  // let the edge happen, then compare on the falling edge.
  task automatic tick();
    int         e;
    logic       xfer;
    logic       bnd;
    logic       sw;
    logic       phase_off;
    logic [7:0] seg;
    logic [7:0] old_sh [8];
    e    = m_cyc + 1;
    xfer = m_vld && rdy;
    bnd  = xfer && (m_digit == 7);
    sw   = bnd && (m_pending || commit);
    for (int i = 0; i < 8; i++) old_sh[i] = m_shadow[i];
    if (sw) begin
      for (int i = 0; i < 8; i++) m_active[i] = old_sh[i];
      m_pending = 1'b0;
    end else if (commit) begin
      m_pending = 1'b1;
    end
    if (wr_en) m_shadow[wr_addr] = wr_seg;
    m_fd = bnd;
    if (xfer) begin
      $display("xfer digit=%0d dat=%h frame_end=%0d swap=%0d t=%0t", m_digit, m_dat, bnd, sw, $time);
      if (bnd) n_frames++;
      m_vld       = 1'b0;
      m_digit     = (m_digit + 1) % 8;
      m_next_rise = e + SD;
    end else if (!m_vld && (e == m_next_rise)) begin
      phase_off = (((e - 1) / BD) % 2) == 1;
      if (blank) seg = 8'hFF;
      else if (phase_off && blink_mask[m_digit]) seg = 8'hFF;
      else seg = m_active[m_digit];
      m_dat = {seg, 8'(1 << m_digit)};
      m_vld = 1'b1;
    end
    m_cyc = e;
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  // Advance with rdy=1 until digit d is being offered.
  task automatic wait_digit(input int d);
    int budget;
    logic [2:0] d3;
    budget = 200;
    d3 = d[2:0];
    rdy = 1'b1;
    while (!(m_vld && m_digit == d) && budget > 0) begin
      tick();
      budget--;
    end
    check_eq($sformatf("reach_digit%0d", d), {vld, cur_digit}, {1'b1, d3});
  endtask

  task automatic commit_frame(input logic [7:0] v);
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_seg = v;
      tick();
    end
    wr_en = 1'b0;
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_addr = 3'd0; wr_seg = 8'h00;
    commit = 1'b0; blank = 1'b0; blink_mask = 8'h00; rdy = 1'b1;
    n_frames = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();
    rst = 1'b1;

    // Free run with rdy=1: two full frames of blank digits.
    repeat (90) tick();

    // Fill shadow with C0 and commit mid-frame.
    wait_digit(2);
    commit_frame(8'hC0);
    check_eq("pending_after_commit", commit_pending, 1'b1);
    repeat (100) tick();

    // Backpressure on digit 3.
    wait_digit(3);
    rdy = 1'b0;
    repeat (20) tick();
    rdy = 1'b1;
    tick();
    check_eq("bp_next_digit", cur_digit, 3'd4);

    // Commit and write addr 0 on the digit-7 transfer cycle.
    wait_digit(7);
    commit = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_seg = 8'h92;
    tick();
    commit = 1'b0; wr_en = 1'b0;
    repeat (60) tick();
    commit = 1'b1; tick(); commit = 1'b0;
    repeat (100) tick();

    // Blink on digit 4, then blank everything.
    commit_frame(8'hA4);
    blink_mask = 8'h10;
    repeat (300) tick();
    blank = 1'b1;
    repeat (60) tick();
    blank = 1'b0;

    // Randomized traffic.
    for (int n = 0; n < 2500; n++) begin
      rdy     = ($urandom % 4) != 0;
      wr_en   = ($urandom % 3) == 0;
      wr_addr = 3'($urandom);
      wr_seg  = 8'($urandom);
      commit  = ($urandom % 40) == 0;
      if (($urandom % 150) == 0) blank = ~blank;
      if (($urandom % 100) == 0) blink_mask = 8'($urandom);
      tick();
    end
    wr_en = 1'b0; commit = 1'b0; blank = 1'b0;

    // Asynchronous reset while digit 5 is being offered with a commit pending.
    wait_digit(4);
    commit = 1'b1; tick(); commit = 1'b0;
    wait_digit(5);
    rdy = 1'b0;
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst = 1'b1;
    for (int n = 0; n < 150; n++) begin
      rdy = ($urandom % 3) != 0;
      tick();
    end

    check_eq("frames_seen_nonzero", (n_frames > 20), 1'b1);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
